// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: 720p60 defaults, port widths
// and the sprite pipeline latency that the delayed sync qualifiers must match.
package video_timing_pkg;

  localparam int unsigned DEF_ACTIVE_H = 1280;
  localparam int unsigned DEF_H_FP     = 110;
  localparam int unsigned DEF_H_SYNC   = 40;
  localparam int unsigned DEF_H_BP     = 220;
  localparam int unsigned DEF_ACTIVE_V = 720;
  localparam int unsigned DEF_V_FP     = 5;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BP     = 20;
  localparam int unsigned DEF_FPS      = 60;

  localparam int unsigned H_TOTAL = DEF_ACTIVE_H + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_ACTIVE_V + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned H_CNT_W  = $clog2(H_TOTAL);
  localparam int unsigned V_CNT_W  = $clog2(V_TOTAL);
  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;
  localparam int unsigned FC_W     = 6;

  localparam int unsigned SPRITE_LATENCY = 4;

  // Half-open window test [lo, lo+len) on unsigned positions.
  function automatic logic in_window(input int unsigned pos, input int unsigned lo,
                                     input int unsigned len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Generic shift register with async active-low reset; DEPTH=0 is a pass-through.
module sync_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_bypass
    logic w_unused;
    assign w_unused = i_clk ^ i_rst_n;
    assign o_q      = i_d;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stages [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) r_stages[i] <= '0;
      end else begin
        r_stages[0] <= i_d;
        for (int i = 1; i < int'(DEPTH); i++) r_stages[i] <= r_stages[i-1];
      end
    end

    assign o_q = r_stages[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: scan position, syncs, active-draw, frame pulse/count,
// plus sync/active copies delayed to line up with the sprite pipeline output.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_H   = DEF_ACTIVE_H,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned ACTIVE_V   = DEF_ACTIVE_V,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned FPS        = DEF_FPS,
  parameter int unsigned SYNC_DELAY = SPRITE_LATENCY
) (
  input  logic                pixel_clk_in,
  input  logic                rst_n_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic                ad_out,
  output logic                nf_out,
  output logic [FC_W-1:0]     fc_out,
  output logic                hs_d_out,
  output logic                vs_d_out,
  output logic                ad_d_out
);

  localparam int unsigned LINE_TOTAL  = ACTIVE_H + H_FP + H_SYNC + H_BP;
  localparam int unsigned FRAME_TOTAL = ACTIVE_V + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(LINE_TOTAL);
  localparam int unsigned VW = $clog2(FRAME_TOTAL);
  localparam int unsigned FW = (FPS > 1) ? $clog2(FPS) : 1;

  if (LINE_TOTAL < 2 || FRAME_TOTAL < 2 || FPS < 1 ||
      LINE_TOTAL > (1 << HCOUNT_W) || FRAME_TOTAL > (1 << VCOUNT_W) ||
      FPS > (1 << FC_W)) begin : g_bad_params
    $error("video_timing_gen: timing parameters do not fit the port widths");
  end

  // r_h/r_v hold the position that the next edge will present on the ports.
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [FW-1:0] r_fc;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_nf;
  logic          w_hs;
  logic          w_vs;
  logic          w_ad;
  logic [2:0]    w_dq;

  assign w_h_last = (32'(r_h) == LINE_TOTAL - 1);
  assign w_v_last = (32'(r_v) == FRAME_TOTAL - 1);
  assign w_nf     = (32'(r_h) == ACTIVE_H) && (32'(r_v) == ACTIVE_V);
  assign w_hs     = in_window(32'(r_h), ACTIVE_H + H_FP, H_SYNC);
  assign w_vs     = in_window(32'(r_v), ACTIVE_V + V_FP, V_SYNC);
  assign w_ad     = (32'(r_h) < ACTIVE_H) && (32'(r_v) < ACTIVE_V);

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h_last ? '0 : r_h + HW'(1);
      if (w_h_last) r_v <= w_v_last ? '0 : r_v + VW'(1);
    end
  end

  // Frame count advances on the same edge that raises nf_out.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_fc <= '0;
    end else if (w_nf) begin
      r_fc <= (32'(r_fc) == FPS - 1) ? '0 : r_fc + FW'(1);
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      ad_out     <= 1'b0;
      nf_out     <= 1'b0;
    end else begin
      hcount_out <= HCOUNT_W'(r_h);
      vcount_out <= VCOUNT_W'(r_v);
      hs_out     <= w_hs;
      vs_out     <= w_vs;
      ad_out     <= w_ad;
      nf_out     <= w_nf;
    end
  end

  assign fc_out = FC_W'(r_fc);

  sync_delay_line #(
    .WIDTH(3),
    .DEPTH(SYNC_DELAY)
  ) u_sync_delay (
    .i_clk  (pixel_clk_in),
    .i_rst_n(rst_n_in),
    .i_d    ({hs_out, vs_out, ad_out}),
    .o_q    (w_dq)
  );

  assign {hs_d_out, vs_d_out, ad_d_out} = w_dq;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator for the pixel clock domain.
- Produces the scan position (hcount/vcount) plus hsync, vsync and active-draw qualifiers for the 1280x720@60 output.
- Sits directly upstream of the sprite/pixel stages: its hcount_out/vcount_out drive their hcount_in/vcount_in.
- Also emits copies of the sync and active qualifiers delayed by the sprite pipeline latency, so they arrive aligned with the returned RGB.

Parameters:
- ACTIVE_H, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels); line total 1650
- ACTIVE_V, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines); frame total 750
- FPS, 60, frame counter modulus
- SYNC_DELAY, 4, cycles of delay on the *_d_out qualifiers (0 = no delay)

Ports:
- pixel_clk_in  in  1  pixel clock
- rst_n_in  in  1  asynchronous active-low reset
- hcount_out  out  11  horizontal position, 0..1649
- vcount_out  out  10  vertical position, 0..749
- hs_out  out  1  hsync, active-high, aligned with hcount_out
- vs_out  out  1  vsync, active-high, aligned with vcount_out
- ad_out  out  1  active draw: hcount_out<ACTIVE_H and vcount_out<ACTIVE_V
- nf_out  out  1  new-frame pulse, one cycle
- fc_out  out  6  frame count, 0..FPS-1
- hs_d_out  out  1  hs_out delayed SYNC_DELAY cycles
- vs_d_out  out  1  vs_out delayed SYNC_DELAY cycles
- ad_d_out  out  1  ad_out delayed SYNC_DELAY cycles

Behaviour:
- Reset (rst_n_in low, asynchronous assert) forces every output to 0, including all delay-pipeline stages. The next position is reset to (0,0).
- Release of rst_n_in takes effect on the clock edge after it has been synchronously deasserted. On the first rising edge with rst_n_in high, the outputs present pixel (0,0): hcount_out=0, vcount_out=0, ad_out=1, hs_out=0, vs_out=0.
- All outputs are registered; nothing is combinational from counters to ports.
- Horizontal counting:
  - Each edge advances hcount by 1.
  - At 1649 it wraps to 0 and vcount advances.
  - vcount wraps 749 -> 0 on the same edge that hcount wraps 1649 -> 0.
- hs_out=1 iff hcount_out is in [ACTIVE_H+H_FP, ACTIVE_H+H_FP+H_SYNC) = [1390,1430).
- vs_out=1 iff vcount_out is in [ACTIVE_V+V_FP, ACTIVE_V+V_FP+V_SYNC) = [725,730). vs_out is level over whole lines, independent of hcount.
- nf_out:
  - High for exactly one cycle, when (hcount_out,vcount_out)=(ACTIVE_H,ACTIVE_V)=(1280,720), i.e. the first blanking pixel after the last active pixel.
  - fc_out increments on that same output cycle (it shows the new value together with nf_out=1).
  - fc_out wraps FPS-1 -> 0.
- Delayed qualifiers:
  - *_d_out equal the corresponding undelayed output exactly SYNC_DELAY edges earlier.
  - The pipeline shifts every clock.
  - After reset release, *_d_out stay 0 for SYNC_DELAY cycles, then track.
  - SYNC_DELAY=0 makes them identical to the undelayed outputs.
- Reset mid-frame: outputs drop to 0 immediately, without waiting for a clock. The frame restarts at (0,0) after release, and fc_out restarts at 0.
- Width rules:
  - Line total and frame total are computed as localparams.
  - Counters are sized by $clog2 of the totals and zero-extended to the port widths.
  - Comparisons are unsigned.
  - Parameter sets whose totals exceed the port widths are illegal; guard them with an elaboration-time check.

Decomposition:
- Package video_timing_pkg holds:
  - 720p default constants (active/porch/sync values, H_TOTAL=1650, V_TOTAL=750);
  - the counter widths;
  - the default sprite pipeline latency, 4, which is the SYNC_DELAY default.
- Sub-module sync_delay_line (parameter WIDTH, DEPTH):
  - generic async-active-low-reset shift register;
  - instantiated once with WIDTH=3 for {hs,vs,ad};
  - DEPTH=0 case is a pass-through.

Test Plan:
- Reset held 10 cycles, then released -> all outputs 0 during reset; first edge after release gives hcount_out=0, vcount_out=0, ad_out=1; *_d_out remain 0 for 4 cycles, and ad_d_out=1 on the 5th edge.
- Run one line from (0,0) -> ad_out falls at hcount_out=1280; hs_out rises at 1390 and falls at 1430 (40 cycles high); at hcount_out=1649 the next edge gives hcount_out=0, vcount_out=1.
- Run a full frame -> vs_out high for vcount_out 725..729 (5x1650=8250 cycles); nf_out pulses once at (1280,720); fc_out goes 0->1 on that cycle; the frame period is exactly 1,237,500 cycles.
- Run 60 frames -> fc_out counts 0..59 and wraps to 0 on the 60th nf_out pulse; exactly 60 nf_out pulses are seen.
- Assert rst_n_in asynchronously mid-cycle at (700,300) -> outputs go to 0 before the next edge; after release the scan restarts at (0,0) with fc_out=0.
- Instantiate with SYNC_DELAY=0 and with SYNC_DELAY=7 -> *_d_out match hs/vs/ad_out with zero and seven cycles lag respectively, over a full line including the hsync edges.
